wb_matmul_engine: RTL

Parametrised Wishbone-slave matrix-multiply engine: the next generation of the team's AI accelerator top. Software loads signed operand matrices A (M×K) and B (K×N) into on-chip buffers, programs dimensions, writes a start bit, and reads back C = A·B, or C += A·B in accumulate mode. A single sequential MAC walks the result one element at a time. It sits directly on the SoC Wishbone bus.

---
 rtl/wb_matmul_pkg.sv | 30 +++
 rtl/matmul_mac_unit.sv | 41 ++++
 rtl/wb_matmul_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_matmul_pkg.sv
// Shared constants for the Wishbone matrix-multiply engine: bus regions,
// register word indices, CTRL/STATUS bit positions and the sequencer states.
package wb_matmul_pkg;

    localparam int ACC_W = 32;

    localparam logic [1:0] REGION_REG = 2'd0;
    localparam logic [1:0] REGION_A   = 2'd1;
    localparam logic [1:0] REGION_B   = 2'd2;
    localparam logic [1:0] REGION_C   = 2'd3;

    // Register offsets expressed as word indices (byte offset >> 2)
    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_DIMS   = 2;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ACC_BIT    = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_OVF_BIT  = 2;
    localparam int STATUS_ERR_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WB
    } state_e;

endpackage

// File: rtl/matmul_mac_unit.sv
// Signed multiply-accumulate step for the matmul engine: seed selection plus
// one product add. Saturating add when MATMUL_SAT_EN is defined, else wraps.
module matmul_mac_unit
    import wb_matmul_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     first,
    input  logic                     accumulate,
    input  logic signed [ACC_W-1:0]  c_seed,
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic                     overflow
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    base;
`ifdef MATMUL_SAT_EN
    logic signed [ACC_W:0]      sum;
`endif

    // The first term of each element starts from zero or from the old C value
    always_comb begin
        product = a * b;
        base    = first ? (accumulate ? c_seed : '0) : acc;
`ifdef MATMUL_SAT_EN
        sum      = (ACC_W+1)'(base) + (ACC_W+1)'(product);
        overflow = sum[ACC_W] != sum[ACC_W-1];
        acc_next = sum[ACC_W-1:0];
        if (overflow) begin
            acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        acc_next = base + ACC_W'(product);
        overflow = 1'b0;
`endif
    end

endmodule

// File: rtl/wb_matmul_engine.sv
// Wishbone-slave matrix-multiply engine: operand/result buffers, register file
// and the MAC/writeback sequencer. Optional saturation via MATMUL_SAT_EN.
module wb_matmul_engine
    import wb_matmul_pkg::*;
#(
    parameter int DIM_MAX = 8,
    parameter int DATA_W  = 16
) (
    input  logic        wishbone_clk_i,
    input  logic        wishbone_rst_ni,
    input  logic [31:0] wishbone_addr_i,
    input  logic        wishbone_we_i,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_stb,
    output logic        wishbone_ack,
    output logic [31:0] wishbone_data_o,
    output logic        irq_o
);

    localparam int DEPTH = DIM_MAX * DIM_MAX;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(REG_CTRL);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(REG_STATUS);
    localparam logic [IDX_W-1:0] IDX_DIMS   = IDX_W'(REG_DIMS);

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    logic [ACC_W-1:0]  c_mem [DEPTH];

    state_e           state;
    logic [7:0]       dim_m, dim_k, dim_n;
    logic [7:0]       row_i, col_j, k_cnt;
    logic             ctrl_acc;
    logic             st_done, st_ovf, st_err;
    logic [ACC_W-1:0] acc, acc_next;
    logic             mac_ovf;

    logic             bus_req, wr_req, busy, idx_ok, busy_block, dims_ok;
    logic [1:0]       region;
    logic [IDX_W-1:0] idx;
    logic [31:0]      read_data;
    logic [DATA_W-1:0] a_op, b_op;
    logic [ACC_W-1:0]  c_seed;
    logic             unused_addr;

    function automatic logic [IDX_W-1:0] elem_idx(input logic [7:0] r, input logic [7:0] c);
        return IDX_W'(16'(r) * 16'(DIM_MAX) + 16'(c));
    endfunction

    assign bus_req     = wishbone_stb & ~wishbone_ack;
    assign wr_req      = bus_req & wishbone_we_i;
    assign region      = wishbone_addr_i[13:12];
    assign idx         = wishbone_addr_i[2 +: IDX_W];
    assign busy        = state != ST_IDLE;
    assign unused_addr = ^{wishbone_addr_i[31:14], wishbone_addr_i[11:2+IDX_W], wishbone_addr_i[1:0]};

    generate
        if (DEPTH == (1 << IDX_W)) begin : g_idx_full
            assign idx_ok = 1'b1;
        end else begin : g_idx_part
            assign idx_ok = 32'(idx) < DEPTH;
        end
    endgenerate

    // While busy only STATUS (W1C) and unused register slots accept writes quietly
    assign busy_block = wr_req && busy &&
                        (region != REGION_REG || idx == IDX_CTRL || idx == IDX_DIMS);
    assign dims_ok = (dim_m != 8'd0) && (dim_m <= 8'(DIM_MAX)) &&
                     (dim_k != 8'd0) && (dim_k <= 8'(DIM_MAX)) &&
                     (dim_n != 8'd0) && (dim_n <= 8'(DIM_MAX));

    assign a_op   = a_mem[elem_idx(row_i, k_cnt)];
    assign b_op   = b_mem[elem_idx(k_cnt, col_j)];
    assign c_seed = c_mem[elem_idx(row_i, col_j)];

    matmul_mac_unit #(.DATA_W(DATA_W)) u_mac (
        .a          (a_op),
        .b          (b_op),
        .first      (k_cnt == 8'd0),
        .accumulate (ctrl_acc),
        .c_seed     (c_seed),
        .acc        (acc),
        .acc_next   (acc_next),
        .overflow   (mac_ovf)
    );

    always_comb begin
        read_data = '0;
        if (idx_ok) begin
            case (region)
                REGION_REG: begin
                    case (idx)
                        IDX_CTRL:   read_data[CTRL_ACC_BIT] = ctrl_acc;
                        IDX_STATUS: begin
                            read_data[STATUS_BUSY_BIT] = busy;
                            read_data[STATUS_DONE_BIT] = st_done;
                            read_data[STATUS_OVF_BIT]  = st_ovf;
                            read_data[STATUS_ERR_BIT]  = st_err;
                        end
                        IDX_DIMS:   read_data = {8'h00, dim_n, dim_k, dim_m};
                        default:    read_data = '0;
                    endcase
                end
                REGION_A: read_data = 32'($signed(a_mem[idx]));
                REGION_B: read_data = 32'($signed(b_mem[idx]));
                default:  read_data = c_mem[idx];
            endcase
        end
    end

    // Buffers are not reset; bus writes land only while idle, so they never
    // collide with the sequencer's C writeback.
    always_ff @(posedge wishbone_clk_i) begin
        if (wr_req && !busy && idx_ok) begin
            case (region)
                REGION_A: a_mem[idx] <= wishbone_data_i[DATA_W-1:0];
                REGION_B: b_mem[idx] <= wishbone_data_i[DATA_W-1:0];
                REGION_C: c_mem[idx] <= wishbone_data_i;
                default:  ;
            endcase
        end
        if (state == ST_WB) begin
            c_mem[elem_idx(row_i, col_j)] <= acc;
        end
    end

    always_ff @(posedge wishbone_clk_i or negedge wishbone_rst_ni) begin
        if (!wishbone_rst_ni) begin
            state           <= ST_IDLE;
            wishbone_ack    <= 1'b0;
            wishbone_data_o <= '0;
            irq_o           <= 1'b0;
            dim_m           <= '0;
            dim_k           <= '0;
            dim_n           <= '0;
            ctrl_acc        <= 1'b0;
            st_done         <= 1'b0;
            st_ovf          <= 1'b0;
            st_err          <= 1'b0;
            row_i           <= '0;
            col_j           <= '0;
            k_cnt           <= '0;
            acc             <= '0;
        end else begin
            wishbone_ack <= bus_req;
            irq_o        <= 1'b0;
            if (bus_req) begin
                wishbone_data_o <= wishbone_we_i ? 32'h0 : read_data;
            end
            if (wr_req && region == REGION_REG && idx == IDX_STATUS) begin
                if (wishbone_data_i[STATUS_DONE_BIT]) st_done <= 1'b0;
                if (wishbone_data_i[STATUS_OVF_BIT])  st_ovf  <= 1'b0;
                if (wishbone_data_i[STATUS_ERR_BIT])  st_err  <= 1'b0;
            end
            if (busy_block) begin
                st_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (wr_req && region == REGION_REG && idx == IDX_DIMS) begin
                        dim_m <= wishbone_data_i[7:0];
                        dim_k <= wishbone_data_i[15:8];
                        dim_n <= wishbone_data_i[23:16];
                    end
                    if (wr_req && region == REGION_REG && idx == IDX_CTRL) begin
                        ctrl_acc <= wishbone_data_i[CTRL_ACC_BIT];
                        if (wishbone_data_i[CTRL_START_BIT]) begin
                            if (dims_ok) begin
                                state   <= ST_MAC;
                                row_i   <= '0;
                                col_j   <= '0;
                                k_cnt   <= '0;
                                st_done <= 1'b0;
                                st_ovf  <= 1'b0;
                            end else begin
                                st_err  <= 1'b1;
                            end
                        end
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    if (mac_ovf) st_ovf <= 1'b1;
                    if (k_cnt == dim_k - 8'd1) begin
                        state <= ST_WB;
                    end else begin
                        k_cnt <= k_cnt + 8'd1;
                    end
                end
                ST_WB: begin
                    k_cnt <= '0;
                    state <= ST_MAC;
                    if (col_j == dim_n - 8'd1) begin
                        col_j <= '0;
                        if (row_i == dim_m - 8'd1) begin
                            state   <= ST_IDLE;
                            st_done <= 1'b1;
                            irq_o   <= 1'b1;
                        end else begin
                            row_i <= row_i + 8'd1;
                        end
                    end else begin
                        col_j <= col_j + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
